// File: rtl/alu_mdu.sv
// Multi-cycle EX-stage execute unit: single-cycle base ALU plus iterative
// radix-2 RV32M multiply/divide, behind valid/ready request and response handshakes.

package alu_mdu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;
endpackage

module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  alu_op_t               alu_op,
   input  logic                  md_en,
   input  logic [2:0]            md_op,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  busy
);

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [W-1:0] alu_calc(input alu_op_t op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (op)
         ALU_ADD:  alu_calc = a + b;
         ALU_SUB:  alu_calc = a - b;
         ALU_AND:  alu_calc = a & b;
         ALU_OR:   alu_calc = a | b;
         ALU_XOR:  alu_calc = a ^ b;
         ALU_SLT:  alu_calc = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_calc = {{(W-1){1'b0}}, (a < b)};
         ALU_SLL:  alu_calc = a << sh;
         ALU_SRL:  alu_calc = a >> sh;
         ALU_SRA:  alu_calc = W'($signed(a) >>> sh);
         default:  alu_calc = '0;
      endcase
   endfunction

   state_t             state_r, state_nxt;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt;
   // Multiply: {accumulator, multiplier}. Divide: {partial remainder, dividend/quotient}.
   logic [2*W-1:0]     prod_r, prod_nxt;
   logic [W-1:0]       opnd_r, opnd_nxt;
   logic               neg_r, neg_nxt;
   logic [2:0]         md_op_r, md_op_nxt;
   logic [W-1:0]       result_r, result_nxt;
   logic               req_ready_r, resp_valid_r, busy_r;

   logic               in_s1_s, in_s2_s, neg1_s, neg2_s, div_zero_s, ovf_s;
   logic [W-1:0]       abs1_s, abs2_s;
   logic [W:0]         mul_sum_s, div_shift_s, div_diff_s;
   logic [2*W-1:0]     step_s, mul_full_s;
   logic [W-1:0]       div_sel_s, final_s;

   // Operand signedness, magnitudes and fast-path detection for an incoming md request
   always_comb begin
      in_s1_s    = md_op inside {3'd1, 3'd2, 3'd4, 3'd6};
      in_s2_s    = md_op inside {3'd1, 3'd4, 3'd6};
      neg1_s     = in_s1_s & operand1[W-1];
      neg2_s     = in_s2_s & operand2[W-1];
      abs1_s     = neg1_s ? (~operand1 + {{(W-1){1'b0}}, 1'b1}) : operand1;
      abs2_s     = neg2_s ? (~operand2 + {{(W-1){1'b0}}, 1'b1}) : operand2;
      div_zero_s = (operand2 == {W{1'b0}});
      ovf_s      = ((md_op == 3'd4) || (md_op == 3'd6)) &&
                   (operand1 == {1'b1, {(W-1){1'b0}}}) && (operand2 == {W{1'b1}});
   end

   // One radix-2 iteration plus the final sign fixup and result selection
   always_comb begin
      mul_sum_s   = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
      div_shift_s = {prod_r[2*W-1:W], prod_r[W-1]};
      div_diff_s  = div_shift_s - {1'b0, opnd_r};
      if (md_op_r[2]) begin
         if (div_diff_s[W]) begin
            step_s = {div_shift_s[W-1:0], prod_r[W-2:0], 1'b0};
         end else begin
            step_s = {div_diff_s[W-1:0], prod_r[W-2:0], 1'b1};
         end
      end else begin
         step_s = {mul_sum_s, prod_r[W-1:1]};
      end
      mul_full_s = neg_r ? (~step_s + {{(2*W-1){1'b0}}, 1'b1}) : step_s;
      div_sel_s  = md_op_r[1] ? step_s[2*W-1:W] : step_s[W-1:0];
      if (md_op_r[2]) begin
         final_s = neg_r ? (~div_sel_s + {{(W-1){1'b0}}, 1'b1}) : div_sel_s;
      end else if (md_op_r == 3'd0) begin
         final_s = mul_full_s[W-1:0];
      end else begin
         final_s = mul_full_s[2*W-1:W];
      end
   end

   // Next-state and datapath register update selection
   always_comb begin
      state_nxt  = state_r;
      cnt_nxt    = cnt_r;
      prod_nxt   = prod_r;
      opnd_nxt   = opnd_r;
      neg_nxt    = neg_r;
      md_op_nxt  = md_op_r;
      result_nxt = result_r;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready_r) begin
                  if (!md_en) begin
                     result_nxt = alu_calc(alu_op, operand1, operand2);
                     state_nxt  = ST_DONE;
                  end else if (md_op[2] && div_zero_s) begin
                     result_nxt = md_op[1] ? operand1 : {W{1'b1}};
                     state_nxt  = ST_DONE;
                  end else if (ovf_s) begin
                     result_nxt = md_op[1] ? {W{1'b0}} : operand1;
                     state_nxt  = ST_DONE;
                  end else begin
                     state_nxt = ST_CALC;
                     cnt_nxt   = CNT_WIDTH'(W);
                     md_op_nxt = md_op;
                     // Remainder takes the dividend's sign; everything else the XOR
                     neg_nxt   = (md_op[2] && md_op[1]) ? neg1_s : (neg1_s ^ neg2_s);
                     prod_nxt  = {{W{1'b0}}, (md_op[2] ? abs1_s : abs2_s)};
                     opnd_nxt  = md_op[2] ? abs2_s : abs1_s;
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_CALC: begin
               prod_nxt = step_s;
               cnt_nxt  = cnt_r - CNT_WIDTH'(1);
               if (cnt_r == CNT_WIDTH'(1)) begin
                  result_nxt = final_s;
                  state_nxt  = ST_DONE;
               end else begin
                  state_nxt = ST_CALC;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         prod_r       <= '0;
         opnd_r       <= '0;
         neg_r        <= 1'b0;
         md_op_r      <= 3'd0;
         result_r     <= '0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         cnt_r        <= cnt_nxt;
         prod_r       <= prod_nxt;
         opnd_r       <= opnd_nxt;
         neg_r        <= neg_nxt;
         md_op_r      <= md_op_nxt;
         result_r     <= result_nxt;
         req_ready_r  <= (state_nxt == ST_IDLE);
         resp_valid_r <= (state_nxt == ST_DONE);
         busy_r       <= (state_nxt != ST_IDLE);
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign busy       = busy_r;
   assign result     = result_r;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vector table, handshake corner
// sequences, and randomized ops against an arithmetic reference model.

module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, req_valid, req_ready, md_en, resp_valid, resp_ready, busy;
   logic [31:0] operand1, operand2, result;
   logic [2:0]  md_op;
   alu_op_t     alu_op;

   int n_vec = 0;
   int n_err = 0;

   alu_mdu #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .operand1(operand1), .operand2(operand2), .alu_op(alu_op), .md_en(md_en),
      .md_op(md_op), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        md;
      alu_op_t     aop;
      logic [2:0]  mop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [5:0]  lat;
   } vec_t;

   vec_t tbl [0:22];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic md, input alu_op_t aop, input logic [2:0] mop,
                                         input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      if (!md) begin
         case (aop)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return (ia < ib) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << (b % 32);
            ALU_SRL:  return a >> (b % 32);
            ALU_SRA:  return 32'(ia >>> (b % 32));
            default:  return 32'd0;
         endcase
      end
      case (mop)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic md, input logic [2:0] mop,
                                    input logic [31:0] a, input logic [31:0] b);
      if (!md) return 1;
      if (mop >= 3'd4 && b == 32'd0) return 1;
      if ((mop == 3'd4 || mop == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Present a request at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic md, input alu_op_t aop, input logic [2:0] mop,
                        input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      md_en = md; alu_op = aop; md_op = mop; operand1 = a; operand2 = b;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      operand1  = $urandom;
      operand2  = $urandom;
      md_op     = 3'($urandom_range(0, 7));
      alu_op    = alu_op_t'(4'($urandom_range(0, 9)));
      md_en     = ~md;
   endtask

   task automatic wait_resp(output logic [31:0] res, output int lat);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) lat = -1;
      res = result;
   endtask

   task automatic retire();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] res, hold;
      int          lat, seen;
      logic        md;
      alu_op_t     aop;
      logic [2:0]  mop;
      logic [31:0] a, b;

      tbl[0]  = '{1'b0, ALU_ADD,  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 6'd1};
      tbl[1]  = '{1'b0, ALU_SRA,  3'd0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 6'd1};
      tbl[2]  = '{1'b0, ALU_SLT,  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 6'd1};
      tbl[3]  = '{1'b0, ALU_SUB,  3'd0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 6'd1};
      tbl[4]  = '{1'b0, ALU_SLTU, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 6'd1};
      tbl[5]  = '{1'b0, ALU_SLL,  3'd0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 6'd1};
      tbl[6]  = '{1'b0, ALU_SRL,  3'd0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 6'd1};
      tbl[7]  = '{1'b0, ALU_XOR,  3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd1};
      tbl[8]  = '{1'b0, alu_op_t'(4'hF), 3'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 6'd1};
      tbl[9]  = '{1'b1, ALU_ADD,  3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 6'd33};
      tbl[10] = '{1'b1, ALU_ADD,  3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 6'd33};
      tbl[11] = '{1'b1, ALU_ADD,  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd33};
      tbl[12] = '{1'b1, ALU_ADD,  3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 6'd33};
      tbl[13] = '{1'b1, ALU_ADD,  3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 6'd33};
      tbl[14] = '{1'b1, ALU_ADD,  3'd5, 32'd100,       32'd7,         32'd14,        6'd33};
      tbl[15] = '{1'b1, ALU_ADD,  3'd7, 32'd100,       32'd7,         32'd2,         6'd33};
      tbl[16] = '{1'b1, ALU_ADD,  3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 6'd1};
      tbl[17] = '{1'b1, ALU_ADD,  3'd7, 32'd5,         32'd0,         32'd5,         6'd1};
      tbl[18] = '{1'b1, ALU_ADD,  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 6'd1};
      tbl[19] = '{1'b1, ALU_ADD,  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 6'd1};
      tbl[20] = '{1'b1, ALU_ADD,  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33};
      tbl[21] = '{1'b1, ALU_ADD,  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         6'd33};
      tbl[22] = '{1'b0, ALU_AND,  3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 6'd1};

      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      md_en = 1'b0; md_op = 3'd0; alu_op = ALU_ADD; operand1 = 32'd0; operand2 = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_result", result, 32'd0);

      for (int i = 0; i < 23; i++) begin
         issue(tbl[i].md, tbl[i].aop, tbl[i].mop, tbl[i].a, tbl[i].b);
         wait_resp(res, lat);
         chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), {26'd0, tbl[i].lat});
         retire();
      end

      // Backpressure after a MUL completes
      issue(1'b1, ALU_ADD, 3'd0, 32'd12345, 32'd678);
      wait_resp(res, lat);
      chk("bp_result", res, 32'd8369910);
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (result !== 32'd8369910 || req_ready !== 1'b0 || resp_valid !== 1'b1) seen++;
      end
      chk("bp_hold_violations", 32'(seen), 32'd0);
      retire();
      chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
      chk("bp_busy_after", {31'd0, busy}, 32'd0);

      // Flush at CALC cycle 10
      hold = result;
      issue(1'b1, ALU_ADD, 3'd5, 32'hDEAD_BEEF, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
      chk("flush_result_kept", result, hold);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      chk("flush_no_resp", 32'(seen), 32'd0);
      md_en = 1'b0; alu_op = ALU_ADD; operand1 = 32'd1; operand2 = 32'd2;
      req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      chk("flush_req_not_accepted", {31'd0, busy | resp_valid}, 32'd0);
      issue(1'b0, ALU_ADD, 3'd0, 32'd40, 32'd2);
      wait_resp(res, lat);
      chk("post_flush_add", res, 32'd42);
      retire();

      // Reset at CALC cycle 5
      issue(1'b1, ALU_ADD, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", result, 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      chk("rst_no_resp", 32'(seen), 32'd0);

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         md  = 1'($urandom_range(0, 1));
         aop = alu_op_t'(4'($urandom_range(0, 10)));
         mop = 3'($urandom_range(0, 7));
         a   = pick();
         b   = pick();
         issue(md, aop, mop, a, b);
         wait_resp(res, lat);
         chk($sformatf("rnd%0d_result md=%0d op=%0d/%0d a=%08h b=%08h", i, md, aop, mop, a, b),
             res, model(md, aop, mop, a, b));
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_lat(md, mop, a, b)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         chk($sformatf("rnd%0d_held", i), result, res);
         retire();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
